// File: rtl/iob_axi_wr_burst_split_pkg.sv
// Shared AXI constants, helpers and FSM encoding for the write burst splitter.
package iob_axi_wr_burst_split_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int AXI_PAGE_BYTES = 4096;
    localparam int AXI_PAGE_W     = 12;

    function automatic int axi_size(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_RESP  = 3'd3,
        ST_SRESP = 3'd4
    } state_e;

endpackage

// File: rtl/iob_axi_wr_burst_split_sub_len.sv
// Sub-burst length: smallest of remaining beats, MAX_BEATS and beats left in the 4 KiB page.
module iob_axi_wr_burst_split_sub_len
    import iob_axi_wr_burst_split_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic [LEN_W:0]      rem_i,
    input  logic [AXI_PAGE_W-1:0] addr_lo_i,
    output logic [LEN_W:0]      sub_o
);

    localparam int SIZE = axi_size(DATA_W);
    localparam int PW   = AXI_PAGE_W + 1;
    localparam int CW   = (LEN_W + 1 > PW) ? LEN_W + 1 : PW;

    logic [PW-1:0] page_bytes;
    logic [CW-1:0] rem_ext;
    logic [CW-1:0] page_beats;
    logic [CW-1:0] max_ext;
    logic [CW-1:0] sub_w;

    always_comb begin
        page_bytes = PW'(AXI_PAGE_BYTES) - {1'b0, addr_lo_i};
        rem_ext    = CW'(rem_i);
        page_beats = CW'(page_bytes >> SIZE);
        max_ext    = CW'(MAX_BEATS);
        sub_w      = rem_ext;
        if (max_ext < sub_w) begin
            sub_w = max_ext;
        end
        if (page_beats < sub_w) begin
            sub_w = page_beats;
        end
        sub_o = sub_w[LEN_W:0];
    end

endmodule

// File: rtl/iob_axi_wr_burst_split.sv
// AXI4 write burst splitter: limits sub-bursts to MAX_BEATS and 4 KiB pages, merges B responses.
//  state    | meaning
//  ST_IDLE  | ready for an upstream AW
//  ST_ADDR  | presenting a sub-burst AW downstream
//  ST_DATA  | passing W beats through, counting to the sub-burst length
//  ST_RESP  | collecting the sub-burst B response
//  ST_SRESP | presenting the merged B response upstream
module iob_axi_wr_burst_split
    import iob_axi_wr_burst_split_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 1,
    parameter int LEN_W     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic [ID_W-1:0]     s_axi_awid_i,
    input  logic [ADDR_W-1:0]   s_axi_awaddr_i,
    input  logic [LEN_W-1:0]    s_axi_awlen_i,
    input  logic                s_axi_awvalid_i,
    output logic                s_axi_awready_o,

    input  logic [DATA_W-1:0]   s_axi_wdata_i,
    input  logic [DATA_W/8-1:0] s_axi_wstrb_i,
    input  logic                s_axi_wlast_i,
    input  logic                s_axi_wvalid_i,
    output logic                s_axi_wready_o,

    output logic [ID_W-1:0]     s_axi_bid_o,
    output logic [1:0]          s_axi_bresp_o,
    output logic                s_axi_bvalid_o,
    input  logic                s_axi_bready_i,

    output logic [ID_W-1:0]     m_axi_awid_o,
    output logic [ADDR_W-1:0]   m_axi_awaddr_o,
    output logic [LEN_W-1:0]    m_axi_awlen_o,
    output logic [2:0]          m_axi_awsize_o,
    output logic [1:0]          m_axi_awburst_o,
    output logic                m_axi_awlock_o,
    output logic [3:0]          m_axi_awcache_o,
    output logic [2:0]          m_axi_awprot_o,
    output logic                m_axi_awvalid_o,
    input  logic                m_axi_awready_i,

    output logic [DATA_W-1:0]   m_axi_wdata_o,
    output logic [DATA_W/8-1:0] m_axi_wstrb_o,
    output logic                m_axi_wlast_o,
    output logic                m_axi_wvalid_o,
    input  logic                m_axi_wready_i,

    input  logic [ID_W-1:0]     m_axi_bid_i,
    input  logic [1:0]          m_axi_bresp_i,
    input  logic                m_axi_bvalid_i,
    output logic                m_axi_bready_o,

    output logic                error_o
);

    localparam int              SIZE       = axi_size(DATA_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((1 << SIZE) - 1));
    localparam logic [LEN_W:0]  LEN_ONE    = {{LEN_W{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W:0]      rem_q, rem_d;
    logic [LEN_W:0]      beat_q, beat_d;
    logic [1:0]          resp_q, resp_d;
    logic                error_q, error_d;

    logic [LEN_W:0]      sub;
    logic [LEN_W:0]      sub_m1;
    logic                sub_last_beat;
    logic                final_beat;
    logic                unused_bid;

    iob_axi_wr_burst_split_sub_len #(
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .MAX_BEATS (MAX_BEATS)
    ) u_sub_len (
        .rem_i     (rem_q),
        .addr_lo_i (addr_q[AXI_PAGE_W-1:0]),
        .sub_o     (sub)
    );

    // addr/rem only move at the end of a sub-burst, so sub stays stable through ADDR and DATA
    assign sub_m1        = sub - LEN_ONE;
    assign sub_last_beat = (beat_q == sub_m1);
    assign final_beat    = sub_last_beat && (sub == rem_q);

    always_comb begin
        state_d         = state_q;
        id_d            = id_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        beat_d          = beat_q;
        resp_d          = resp_q;
        error_d         = error_q;
        s_axi_awready_o = 1'b0;
        s_axi_wready_o  = 1'b0;
        s_axi_bvalid_o  = 1'b0;
        m_axi_awvalid_o = 1'b0;
        m_axi_wvalid_o  = 1'b0;
        m_axi_wlast_o   = 1'b0;
        m_axi_bready_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                s_axi_awready_o = 1'b1;
                if (s_axi_awvalid_i) begin
                    id_d    = s_axi_awid_i;
                    addr_d  = s_axi_awaddr_i & ALIGN_MASK;
                    rem_d   = {1'b0, s_axi_awlen_i} + LEN_ONE;
                    beat_d  = '0;
                    resp_d  = AXI_RESP_OKAY;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_axi_awvalid_o = 1'b1;
                if (m_axi_awready_i) begin
                    beat_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axi_wvalid_o = s_axi_wvalid_i;
                s_axi_wready_o = m_axi_wready_i;
                m_axi_wlast_o  = sub_last_beat;
                if (s_axi_wvalid_i && m_axi_wready_i) begin
                    // the beat count ends the transfer; upstream WLAST is only checked
                    if (s_axi_wlast_i != final_beat) begin
                        error_d = 1'b1;
                    end
                    if (sub_last_beat) begin
                        addr_d  = addr_q + (ADDR_W'(sub) << SIZE);
                        rem_d   = rem_q - sub;
                        beat_d  = '0;
                        state_d = ST_RESP;
                    end else begin
                        beat_d = beat_q + LEN_ONE;
                    end
                end
            end
            ST_RESP: begin
                m_axi_bready_o = 1'b1;
                if (m_axi_bvalid_i) begin
                    if (m_axi_bresp_i > resp_q) begin
                        resp_d = m_axi_bresp_i;
                    end
                    state_d = (rem_q == '0) ? ST_SRESP : ST_ADDR;
                end
            end
            ST_SRESP: begin
                s_axi_bvalid_o = 1'b1;
                if (s_axi_bready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            resp_q  <= AXI_RESP_OKAY;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            resp_q  <= resp_d;
            error_q <= error_d;
        end
    end

    // only one upstream burst is ever in flight, so the downstream BID carries no information
    assign unused_bid      = ^m_axi_bid_i;

    assign m_axi_awid_o    = id_q;
    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_awlen_o   = sub_m1[LEN_W-1:0];
    assign m_axi_awsize_o  = 3'(SIZE);
    assign m_axi_awburst_o = AXI_BURST_INCR;
    assign m_axi_awlock_o  = 1'b0;
    assign m_axi_awcache_o = 4'b0011;
    assign m_axi_awprot_o  = 3'b000;

    assign m_axi_wdata_o   = s_axi_wdata_i;
    assign m_axi_wstrb_o   = s_axi_wstrb_i;

    assign s_axi_bid_o     = id_q;
    assign s_axi_bresp_o   = resp_q;
    assign error_o         = error_q;

endmodule

// File: tb/tb_iob_axi_wr_burst_split.sv
// Scoreboard bench for the write burst splitter: directed bursts, random stalls, reset and WLAST checks.
module tb_iob_axi_wr_burst_split;

    logic        clk;
    logic        rst;
    logic [0:0]  s_awid;
    logic [23:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast, s_wvalid, s_wready;
    logic [0:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready;
    logic [0:0]  m_awid;
    logic [23:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_awlock;
    logic [3:0]  m_awcache;
    logic [2:0]  m_awprot;
    logic        m_awvalid, m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast, m_wvalid, m_wready;
    logic [0:0]  m_bid;
    logic [1:0]  m_bresp;
    logic        m_bvalid, m_bready;
    logic        error;

    iob_axi_wr_burst_split #(
        .ADDR_W(24), .DATA_W(32), .ID_W(1), .LEN_W(8), .MAX_BEATS(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axi_awid_i(s_awid), .s_axi_awaddr_i(s_awaddr), .s_axi_awlen_i(s_awlen),
        .s_axi_awvalid_i(s_awvalid), .s_axi_awready_o(s_awready),
        .s_axi_wdata_i(s_wdata), .s_axi_wstrb_i(s_wstrb), .s_axi_wlast_i(s_wlast),
        .s_axi_wvalid_i(s_wvalid), .s_axi_wready_o(s_wready),
        .s_axi_bid_o(s_bid), .s_axi_bresp_o(s_bresp), .s_axi_bvalid_o(s_bvalid), .s_axi_bready_i(s_bready),
        .m_axi_awid_o(m_awid), .m_axi_awaddr_o(m_awaddr), .m_axi_awlen_o(m_awlen),
        .m_axi_awsize_o(m_awsize), .m_axi_awburst_o(m_awburst), .m_axi_awlock_o(m_awlock),
        .m_axi_awcache_o(m_awcache), .m_axi_awprot_o(m_awprot),
        .m_axi_awvalid_o(m_awvalid), .m_axi_awready_i(m_awready),
        .m_axi_wdata_o(m_wdata), .m_axi_wstrb_o(m_wstrb), .m_axi_wlast_o(m_wlast),
        .m_axi_wvalid_o(m_wvalid), .m_axi_wready_i(m_wready),
        .m_axi_bid_i(m_bid), .m_axi_bresp_i(m_bresp), .m_axi_bvalid_i(m_bvalid), .m_axi_bready_o(m_bready),
        .error_o(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [0:0] id; logic [23:0] addr; logic [7:0] len; } aw_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_t;
    typedef struct packed { logic [0:0] id; logic [1:0] resp; } b_t;

    aw_t         exp_aw[$];
    w_t          exp_w[$];
    b_t          exp_b[$];
    logic [1:0]  resp_script[$];
    logic [31:0] mem[int];

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rnd_en   = 1'b0;
    bit   aw_hs_f, w_last_hs_f, b_hs_f;
    int   cur_len, wbeat, sb_count, b_pend;
    logic [23:0] waddr;
    aw_t  e_aw;
    w_t   e_w;
    b_t   e_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: handshakes are stable at the falling edge and complete on the next rising edge
    always @(negedge clk) begin
        aw_hs_f     = m_awvalid && m_awready && !rst;
        w_last_hs_f = m_wvalid && m_wready && m_wlast && !rst;
        b_hs_f      = m_bvalid && m_bready && !rst;
        if (!rst) begin
            if (m_awvalid && m_awready) begin
                check("aw_expected", 64'(exp_aw.size() != 0), 1);
                if (exp_aw.size() != 0) begin
                    e_aw = exp_aw.pop_front();
                    check("m_awaddr", m_awaddr, e_aw.addr);
                    check("m_awlen", m_awlen, e_aw.len);
                    check("m_awid", m_awid, e_aw.id);
                    check("m_awsize", m_awsize, 3'd2);
                    check("m_awburst", {m_awlock, m_awprot, m_awcache, m_awburst}, {1'b0, 3'b000, 4'b0011, 2'b01});
                    cur_len = int'(e_aw.len);
                end
                wbeat = 0;
                waddr = m_awaddr;
            end
            if (m_wvalid && m_wready) begin
                check("w_expected", 64'(exp_w.size() != 0), 1);
                if (exp_w.size() != 0) begin
                    e_w = exp_w.pop_front();
                    check("m_wdata", m_wdata, e_w.data);
                    check("m_wstrb", m_wstrb, e_w.strb);
                end
                check("m_wlast", m_wlast, 64'(wbeat == cur_len));
                mem[int'(waddr >> 2)] = m_wdata;
                waddr = waddr + 24'd4;
                wbeat++;
            end
            if (s_bvalid && s_bready) begin
                check("b_expected", 64'(exp_b.size() != 0), 1);
                if (exp_b.size() != 0) begin
                    e_b = exp_b.pop_front();
                    check("s_bid", s_bid, e_b.id);
                    check("s_bresp", s_bresp, e_b.resp);
                end
                sb_count++;
            end
        end
    end

    // downstream slave: one B per completed sub-burst, responses from resp_script
    initial begin
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00; m_bid = 1'b0;
        s_bready  = 1'b0; b_pend = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                m_bvalid = 1'b0;
                b_pend   = 0;
            end else begin
                if (b_hs_f) m_bvalid = 1'b0;
                if (w_last_hs_f) b_pend++;
                if (!m_bvalid && b_pend > 0) begin
                    m_bvalid = 1'b1;
                    m_bresp  = (resp_script.size() != 0) ? resp_script.pop_front() : 2'b00;
                    b_pend--;
                end
            end
            m_awready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            m_wready  = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            s_bready  = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic push_aw(input logic [0:0] id, input logic [23:0] addr, input logic [7:0] len);
        exp_aw.push_back('{id: id, addr: addr, len: len});
    endtask

    task automatic do_aw(input logic [0:0] id, input logic [23:0] addr, input logic [7:0] len);
        int cnt = 0;
        s_awid = id; s_awaddr = addr; s_awlen = len; s_awvalid = 1'b1;
        @(negedge clk);
        while (!s_awready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("aw_accept", s_awready, 1);
        @(posedge clk); #1;
        s_awvalid = 1'b0;
    endtask

    // last_idx: beat index carrying s_wlast (-1 for none)
    task automatic do_w(input int n_beats, input logic [31:0] base, input int last_idx);
        for (int i = 0; i < n_beats; i++) begin
            int cnt = 0;
            if (rnd_en) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
            end
            s_wvalid = 1'b1;
            s_wdata  = base + 32'(i);
            s_wstrb  = 4'(i) | 4'h1;
            s_wlast  = (i == last_idx);
            exp_w.push_back('{data: s_wdata, strb: s_wstrb});
            @(negedge clk);
            while (!s_wready && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            check("w_accept", s_wready, 1);
            @(posedge clk); #1;
            s_wvalid = 1'b0;
            s_wlast  = 1'b0;
            if (cnt >= 200) return;
        end
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while ((exp_aw.size() + exp_w.size() + exp_b.size()) != 0 && cnt < 2000) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("drain_queues", 64'(exp_aw.size() + exp_w.size() + exp_b.size()), 0);
        exp_aw.delete(); exp_w.delete(); exp_b.delete();
        @(posedge clk); #1;
        check("idle_awready", s_awready, 1);
    endtask

    task automatic run_burst(input logic [0:0] id, input logic [23:0] addr, input logic [7:0] len,
                             input logic [31:0] base, input int last_idx, input logic [1:0] resp);
        exp_b.push_back('{id: id, resp: resp});
        do_aw(id, addr, len);
        do_w(int'(len) + 1, base, last_idx);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_awready"}, s_awready, 1);
        check({tag, "_s_wready"}, s_wready, 0);
        check({tag, "_m_awvalid"}, m_awvalid, 0);
        check({tag, "_m_wvalid"}, m_wvalid, 0);
        check({tag, "_m_bready"}, m_bready, 0);
        check({tag, "_s_bvalid"}, s_bvalid, 0);
        check({tag, "_error"}, error, 0);
    endtask

    initial begin
        int sb_before;
        rst = 1'b1;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
        sb_count = 0; cur_len = 0; wbeat = 0; waddr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("post_reset");

        // single burst inside one sub-burst
        push_aw(1'b0, 24'h000100, 8'd3);
        run_burst(1'b0, 24'h000100, 8'd3, 32'h0000_1000, 3, 2'b00);

        // 40 beats split by MAX_BEATS, exactly one upstream B
        sb_before = sb_count;
        push_aw(1'b0, 24'h000000, 8'd15);
        push_aw(1'b0, 24'h000040, 8'd15);
        push_aw(1'b0, 24'h000080, 8'd7);
        run_burst(1'b0, 24'h000000, 8'd39, 32'h0000_2000, 39, 2'b00);
        check("one_s_bvalid", 64'(sb_count - sb_before), 1);

        // 4 KiB crossing
        push_aw(1'b0, 24'h007FD8, 8'd9);
        push_aw(1'b0, 24'h008000, 8'd9);
        run_burst(1'b0, 24'h007FD8, 8'd19, 32'd32, 19, 2'b00);
        for (int i = 0; i < 20; i++) begin
            check("ram_page_cross", mem.exists(32'h1FF6 + i) ? mem[32'h1FF6 + i] : 32'hDEAD_BEEF, 32'(32 + i));
        end

        // SLVERR on the second sub-burst dominates the merged response
        resp_script.push_back(2'b00);
        resp_script.push_back(2'b10);
        resp_script.push_back(2'b00);
        push_aw(1'b1, 24'h000000, 8'd15);
        push_aw(1'b1, 24'h000040, 8'd15);
        push_aw(1'b1, 24'h000080, 8'd7);
        run_burst(1'b1, 24'h000000, 8'd39, 32'h0000_3000, 39, 2'b10);
        check("error_after_slverr", error, 0);

        // 1024 words with random stalls on every handshake
        rnd_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 16; j++) begin
                push_aw(1'(k), 24'h010000 + 24'(k * 32'h400) + 24'(j * 32'h40), 8'd15);
            end
            run_burst(1'(k), 24'h010000 + 24'(k * 32'h400), 8'd255, 32'h0010_0000 + 32'(k * 256), 255, 2'b00);
        end
        rnd_en = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 1024; n++) begin
            check("ram_stall_run", mem.exists(32'h4000 + n) ? mem[32'h4000 + n] : 32'hDEAD_BEEF, 32'h0010_0000 + 32'(n));
        end
        check("error_after_stalls", error, 0);

        // reset while the fifth data beat is being offered
        push_aw(1'b0, 24'h000000, 8'd15);
        do_aw(1'b0, 24'h000000, 8'd15);
        do_w(4, 32'h0000_5000, -1);
        s_wvalid = 1'b1; s_wdata = 32'h0000_5004; s_wstrb = 4'hF;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("mid_reset");
        s_wvalid = 1'b0;
        rst = 1'b0;
        exp_aw.delete(); exp_w.delete(); exp_b.delete();
        @(posedge clk); #1;
        check_reset_outputs("after_mid_reset");

        // early upstream WLAST raises the sticky error, transfer still completes by beat count
        push_aw(1'b0, 24'h000200, 8'd3);
        run_burst(1'b0, 24'h000200, 8'd3, 32'h0000_6000, 1, 2'b00);
        check("error_early_wlast", error, 1);
        push_aw(1'b0, 24'h000300, 8'd1);
        run_burst(1'b0, 24'h000300, 8'd1, 32'h0000_7000, 1, 2'b00);
        check("error_sticky", error, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("error_cleared", error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
